// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC in the clk_200 domain,
// decodes frames for PHY_ADDR and serves a 32 x 16-bit register file.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0DD0,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        clk_200,
  input  logic        sys_rstn,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [15:0] status_i,
  output logic        reg_wr_o,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  output logic        soft_rst_o
);

  typedef enum logic [3:0] {
    IDLE, ST1, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP
  } state_t;

  localparam logic [12:0] TO_LIMIT = 13'(TIMEOUT);

  state_t      state, state_n;
  logic        mdc_q1, mdc_q2, mdc_q3;
  logic        mdio_q1, mdio_q2;
  logic        rise, fall, bit_in;
  logic [5:0]  pre_cnt, pre_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic        is_read, is_read_n;
  logic        op_msb, op_msb_n;
  logic [4:0]  phyad, phyad_n;
  logic [4:0]  regad, regad_n;
  logic [14:0] wdata, wdata_n;
  logic [15:0] wr_word;
  logic [15:0] rd_word, rd_word_n;
  logic [15:0] rd_mux;
  logic [4:0]  rd_addr;
  logic        mdio_o_n, mdio_t_n;
  logic        commit;
  logic [12:0] to_cnt;
  logic [15:0] regs [0:31];

  assign rise    = mdc_q2 & ~mdc_q3;
  assign fall    = ~mdc_q2 & mdc_q3;
  assign bit_in  = mdio_q2;
  assign wr_word = {wdata, bit_in};
  assign rd_addr = {regad[3:0], bit_in};

  // Read word source for the address completing on this rise.
  always_comb begin
    rd_mux = regs[rd_addr];
    unique case (rd_addr)
      5'd0:    rd_mux = {1'b0, regs[0][14:0]};
      5'd1:    rd_mux = status_i;
      5'd2:    rd_mux = PHY_ID1;
      5'd3:    rd_mux = PHY_ID2;
      default: rd_mux = regs[rd_addr];
    endcase
  end

  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    bit_cnt_n = bit_cnt;
    is_read_n = is_read;
    op_msb_n  = op_msb;
    phyad_n   = phyad;
    regad_n   = regad;
    wdata_n   = wdata;
    rd_word_n = rd_word;
    mdio_o_n  = mdio_o;
    mdio_t_n  = mdio_t;
    commit    = 1'b0;
    unique case (state)
      IDLE: if (rise) begin
        if (bit_in) begin
          pre_cnt_n = (pre_cnt == 6'd63) ? pre_cnt : pre_cnt + 6'd1;
        end else begin
          pre_cnt_n = '0;
          if (pre_cnt >= 6'd32) state_n = ST1;
        end
      end
      ST1: if (rise) begin
        bit_cnt_n = '0;
        state_n   = bit_in ? OP : IDLE;
      end
      OP: if (rise) begin
        if (bit_cnt == 5'd0) begin
          op_msb_n  = bit_in;
          bit_cnt_n = 5'd1;
        end else begin
          bit_cnt_n = '0;
          is_read_n = op_msb & ~bit_in;
          state_n   = (op_msb ^ bit_in) ? PHYAD : IDLE;
        end
      end
      PHYAD: if (rise) begin
        phyad_n   = {phyad[3:0], bit_in};
        bit_cnt_n = bit_cnt + 5'd1;
        if (bit_cnt == 5'd4) begin
          bit_cnt_n = '0;
          state_n   = REGAD;
        end
      end
      REGAD: if (rise) begin
        regad_n   = rd_addr;
        bit_cnt_n = bit_cnt + 5'd1;
        if (bit_cnt == 5'd4) begin
          bit_cnt_n = '0;
          if (phyad == PHY_ADDR) begin
            state_n   = TA;
            rd_word_n = rd_mux;
          end else begin
            state_n = SKIP;
          end
        end
      end
      TA: begin
        if (rise) begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (!is_read && bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            state_n   = WR_DATA;
          end
        end
        // Read: bus turns around on the fall following the TA bit 1 rise.
        if (fall && is_read && bit_cnt == 5'd1) begin
          bit_cnt_n = '0;
          mdio_t_n  = 1'b0;
          mdio_o_n  = 1'b0;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: if (fall) begin
        if (bit_cnt == 5'd16) begin
          mdio_t_n = 1'b1;
          mdio_o_n = 1'b0;
          state_n  = IDLE;
        end else begin
          mdio_o_n  = rd_word[15];
          rd_word_n = {rd_word[14:0], 1'b0};
          bit_cnt_n = bit_cnt + 5'd1;
        end
      end
      WR_DATA: if (rise) begin
        wdata_n   = wr_word[14:0];
        bit_cnt_n = bit_cnt + 5'd1;
        if (bit_cnt == 5'd15) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      SKIP: if (rise) begin
        bit_cnt_n = bit_cnt + 5'd1;
        if (bit_cnt == 5'd17) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && to_cnt == TO_LIMIT) begin
      state_n  = IDLE;
      mdio_t_n = 1'b1;
      commit   = 1'b0;
    end
  end

  always_ff @(posedge clk_200 or negedge sys_rstn) begin
    if (!sys_rstn) begin
      mdc_q1      <= 1'b0;
      mdc_q2      <= 1'b0;
      mdc_q3      <= 1'b0;
      mdio_q1     <= 1'b1;
      mdio_q2     <= 1'b1;
      state       <= IDLE;
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      is_read     <= 1'b0;
      op_msb      <= 1'b0;
      phyad       <= '0;
      regad       <= '0;
      wdata       <= '0;
      rd_word     <= '0;
      mdio_o      <= 1'b0;
      mdio_t      <= 1'b1;
      to_cnt      <= '0;
      reg_wr_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      soft_rst_o  <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= (i == 0) ? 16'h1140 : '0;
      end
    end else begin
      mdc_q1  <= mdc_i;
      mdc_q2  <= mdc_q1;
      mdc_q3  <= mdc_q2;
      mdio_q1 <= mdio_i;
      mdio_q2 <= mdio_q1;
      state   <= state_n;
      pre_cnt <= pre_cnt_n;
      bit_cnt <= bit_cnt_n;
      is_read <= is_read_n;
      op_msb  <= op_msb_n;
      phyad   <= phyad_n;
      regad   <= regad_n;
      wdata   <= wdata_n;
      rd_word <= rd_word_n;
      mdio_o  <= mdio_o_n;
      mdio_t  <= mdio_t_n;
      if (rise || fall) to_cnt <= '0;
      else if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 13'd1;
      reg_wr_o   <= commit;
      soft_rst_o <= commit && (regad == 5'd0) && wr_word[15];
      if (commit) begin
        reg_addr_o  <= regad;
        reg_wdata_o <= wr_word;
        if (regad == 5'd0) regs[0] <= {1'b0, wr_word[14:0]};
        else if (regad >= 5'd4) regs[regad] <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench: a bit-level MDIO master drives frames and results are
// compared against a register-map model of the PHY.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        mdc;
  logic        m_oe, m_val;
  logic        mdio_o, mdio_t;
  logic        mdio_line;
  logic [15:0] status_i;
  logic        reg_wr_o, soft_rst_o;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0, soft_cnt = 0, soft_bad = 0;
  logic [4:0]  last_addr;
  logic [15:0] last_data;
  logic [15:0] mregs [32];

  always #5 clk = ~clk;

  // Shared bus: PHY drive wins when enabled, otherwise master or pull-up.
  assign mdio_line = mdio_t ? (m_oe ? m_val : 1'b1) : mdio_o;

  mdio_phy_responder #(
    .PHY_ADDR(5'd1), .PHY_ID1(16'h0141), .PHY_ID2(16'h0DD0), .TIMEOUT(4096)
  ) dut (
    .clk_200(clk), .sys_rstn(sys_rstn), .mdc_i(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .status_i(status_i),
    .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .soft_rst_o(soft_rst_o)
  );

  always @(negedge clk) begin
    if (reg_wr_o) begin
      wr_cnt++;
      last_addr = reg_addr_o;
      last_data = reg_wdata_o;
    end
    if (soft_rst_o) soft_cnt++;
    if (soft_rst_o && !reg_wr_o) soft_bad++;
  end

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mregs[0] = 16'h1140;
  endfunction

  function automatic void model_write(input int a, input logic [15:0] d);
    if (a == 0) mregs[0] = {1'b0, d[14:0]};
    else if (a >= 4) mregs[a] = d;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    case (a)
      0: return mregs[0];
      1: return status_i;
      2: return 16'h0141;
      3: return 16'h0DD0;
      default: return mregs[a];
    endcase
  endfunction

  task automatic mdc_bit(input logic drv, input logic val, output logic s_t, output logic s_line);
    m_oe  = drv;
    m_val = val;
    repeat (10) @(negedge clk);
    s_t    = mdio_t;
    s_line = mdio_line;
    mdc = 1'b1;
    repeat (10) @(negedge clk);
    mdc = 1'b0;
  endtask

  // nbits: how many of the 32 post-preamble bits to clock (32 = full frame).
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd, input logic is_wr,
                           input int nbits, output logic [15:0] rd, output logic ta2,
                           output int tlow);
    logic [31:0] vec;
    logic s_t, s_l;
    vec  = {2'b01, op, phy, ra, (is_wr ? 2'b10 : 2'b11), wd};
    rd   = '0;
    ta2  = 1'b1;
    tlow = 0;
    for (int i = 0; i < pre; i++) begin
      mdc_bit(1'b1, 1'b1, s_t, s_l);
      if (!s_t) tlow++;
    end
    for (int i = 0; i < nbits; i++) begin
      mdc_bit((i < 14) || is_wr, vec[31-i], s_t, s_l);
      if (!s_t) tlow++;
      if (i == 15) ta2 = s_l;
      if (i >= 16) rd = {rd[14:0], s_l};
    end
    m_oe = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [15:0] rd, output logic ta2, output int tlow);
    run_frame(32, 2'b10, 5'd1, 5'(a), 16'h0000, 1'b0, 32, rd, ta2, tlow);
  endtask

  task automatic do_write(input int a, input logic [15:0] d);
    logic [15:0] rd; logic ta2; int tl;
    run_frame(32, 2'b01, 5'd1, 5'(a), d, 1'b1, 32, rd, ta2, tl);
    repeat (4) @(negedge clk);
    model_write(a, d);
  endtask

  task automatic test_reset();
    logic [15:0] rd; logic ta2; int tl;
    checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL rst_mdio_t: got %b want 1", mdio_t); end
    checks++; if (mdio_o !== 1'b0) begin errors++; $display("FAIL rst_mdio_o: got %b want 0", mdio_o); end
    checks++; if (reg_wr_o !== 1'b0) begin errors++; $display("FAIL rst_reg_wr: got %b want 0", reg_wr_o); end
    checks++; if (soft_rst_o !== 1'b0) begin errors++; $display("FAIL rst_soft: got %b want 0", soft_rst_o); end
    checks++; if (reg_addr_o !== 5'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", reg_addr_o); end
    checks++; if (reg_wdata_o !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", reg_wdata_o); end
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    repeat (5) @(negedge clk);
    do_read(0, rd, ta2, tl);
    checks++; if (rd !== model_read(0)) begin errors++; $display("FAIL rst_reg0: got %h want %h", rd, model_read(0)); end
    do_read(4, rd, ta2, tl);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_reg4: got %h want 0000", rd); end
  endtask

  task automatic test_read_id();
    logic [15:0] rd; logic ta2; int tl;
    do_read(2, rd, ta2, tl);
    checks++; if (ta2 !== 1'b0) begin errors++; $display("FAIL id_ta2: got %b want 0", ta2); end
    checks++; if (rd !== 16'h0141) begin errors++; $display("FAIL id_data: got %h want 0141", rd); end
    checks++; if (tl !== 17) begin errors++; $display("FAIL id_drive_len: got %0d want 17", tl); end
    repeat (8) @(negedge clk);
    checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL id_release: got %b want 1", mdio_t); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic ta2; int tl, w0, s0;
    w0 = wr_cnt; s0 = soft_cnt;
    do_write(9, 16'hBEEF);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
    checks++; if (last_addr !== 5'd9) begin errors++; $display("FAIL wr_addr: got %0d want 9", last_addr); end
    checks++; if (last_data !== 16'hBEEF) begin errors++; $display("FAIL wr_data: got %h want beef", last_data); end
    checks++; if (soft_cnt - s0 !== 0) begin errors++; $display("FAIL wr_soft: got %0d want 0", soft_cnt - s0); end
    do_read(9, rd, ta2, tl);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_readback: got %h want beef", rd); end
  endtask

  task automatic test_soft_reset();
    logic [15:0] rd; logic ta2; int tl, w0, s0;
    w0 = wr_cnt; s0 = soft_cnt;
    do_write(0, 16'h9140);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sr_wr: got %0d want 1", wr_cnt - w0); end
    checks++; if (soft_cnt - s0 !== 1) begin errors++; $display("FAIL sr_soft: got %0d want 1", soft_cnt - s0); end
    checks++; if (soft_bad !== 0) begin errors++; $display("FAIL sr_coincident: got %0d want 0", soft_bad); end
    do_read(0, rd, ta2, tl);
    checks++; if (rd !== 16'h1140) begin errors++; $display("FAIL sr_reg0: got %h want 1140", rd); end
  endtask

  task automatic test_ignored_frames();
    logic [15:0] rd; logic ta2; int tl, tsum, w0;
    w0 = wr_cnt; tsum = 0;
    run_frame(32, 2'b10, 5'd7, 5'd2, 16'h0000, 1'b0, 32, rd, ta2, tl); tsum += tl;
    run_frame(32, 2'b01, 5'd7, 5'd9, 16'hDEAD, 1'b1, 32, rd, ta2, tl); tsum += tl;
    run_frame(31, 2'b01, 5'd1, 5'd9, 16'h1234, 1'b1, 32, rd, ta2, tl); tsum += tl;
    run_frame(32, 2'b11, 5'd1, 5'd9, 16'h5678, 1'b1, 32, rd, ta2, tl); tsum += tl;
    checks++; if (tsum !== 0) begin errors++; $display("FAIL ign_drive: got %0d want 0", tsum); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL ign_wr: got %0d want 0", wr_cnt - w0); end
    do_read(9, rd, ta2, tl);
    checks++; if (rd !== model_read(9)) begin errors++; $display("FAIL ign_next: got %h want %h", rd, model_read(9)); end
    checks++; if (tl !== 17) begin errors++; $display("FAIL ign_next_len: got %0d want 17", tl); end
  endtask

  task automatic test_timeout();
    logic [15:0] rd; logic ta2; int tl, w0;
    w0 = wr_cnt;
    run_frame(32, 2'b10, 5'd1, 5'd5, 16'h0000, 1'b0, 14, rd, ta2, tl);
    repeat (5000) @(negedge clk);
    checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL to_regad: got %b want 1", mdio_t); end
    run_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b0, 20, rd, ta2, tl);
    repeat (8) @(negedge clk);
    checks++; if (mdio_t !== 1'b0) begin errors++; $display("FAIL to_driving: got %b want 0", mdio_t); end
    repeat (5000) @(negedge clk);
    checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL to_data: got %b want 1", mdio_t); end
    run_frame(32, 2'b01, 5'd1, 5'd12, 16'hABCD, 1'b1, 24, rd, ta2, tl);
    repeat (5000) @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL to_nowr: got %0d want 0", wr_cnt - w0); end
    do_read(3, rd, ta2, tl);
    checks++; if (rd !== 16'h0DD0) begin errors++; $display("FAIL to_after: got %h want 0dd0", rd); end
  endtask

  task automatic test_reset_midread();
    logic [15:0] rd; logic ta2; int tl, w0;
    w0 = wr_cnt;
    run_frame(32, 2'b10, 5'd1, 5'd9, 16'h0000, 1'b0, 23, rd, ta2, tl);
    repeat (8) @(negedge clk);
    checks++; if (mdio_t !== 1'b0) begin errors++; $display("FAIL mr_pre: got %b want 0", mdio_t); end
    sys_rstn = 1'b0;
    #1;
    checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL mr_async: got %b want 1", mdio_t); end
    model_reset();
    repeat (5) @(negedge clk);
    sys_rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mr_nowr: got %0d want 0", wr_cnt - w0); end
    do_read(9, rd, ta2, tl);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mr_reg9: got %h want 0000", rd); end
  endtask

  task automatic test_random();
    logic [15:0] rd, d, exp; logic ta2; int tl, a, w0, s0;
    for (int n = 0; n < 16; n++) begin
      status_i = 16'($urandom);
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        w0 = wr_cnt; s0 = soft_cnt;
        do_write(a, d);
        checks++;
        if (wr_cnt - w0 !== 1 || last_addr !== 5'(a) || last_data !== d)
          begin errors++; $display("FAIL rnd_wr: got n=%0d a=%0d d=%h want 1 %0d %h", wr_cnt - w0, last_addr, last_data, a, d); end
        checks++;
        if (soft_cnt - s0 !== ((a == 0 && d[15]) ? 1 : 0))
          begin errors++; $display("FAIL rnd_soft: got %0d for a=%0d d=%h", soft_cnt - s0, a, d); end
      end else begin
        exp = model_read(a);
        do_read(a, rd, ta2, tl);
        checks++;
        if (rd !== exp || ta2 !== 1'b0)
          begin errors++; $display("FAIL rnd_rd: a=%0d got %h ta2=%b want %h ta2=0", a, rd, ta2, exp); end
      end
    end
  endtask

  initial begin
    sys_rstn = 1'b0;
    mdc      = 1'b0;
    m_oe     = 1'b0;
    m_val    = 1'b1;
    status_i = 16'hA5C3;
    model_reset();
    repeat (5) @(negedge clk);
    test_reset();
    test_read_id();
    test_write_read();
    test_soft_reset();
    test_ignored_frames();
    test_timeout();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
